// File: rtl/bus_strobe_ctrl.sv
// bus_strobe_ctrl
// Sequences MCU parallel-bus accesses into the clk domain. The asynchronous RD/WR
// strobes are synchronised and edge-detected. Each access then produces exactly one
// single-cycle read or write strobe to the decoded register page. Read data from
// that page is captured for the pad driver.
//
// Ports
//   clk, rst_n  system clock, asynchronous active-low reset
//   ADDR        MCU address: [11:8] page, [7:0] register offset
//   RD, WR      MCU strobes (active high, asynchronous to clk)
//   din         write data from the pad input buffer
//   rddat       page read data, page k at [k*DW +: DW]
//   dout        registered read data to the pad driver
//   dout_oe     pad output enable
//   wr_stb      one-hot, one-cycle write strobe per page
//   rd_stb      one-hot, one-cycle read strobe per page
//   addr        latched register offset
//   wrdat       latched write data
//   busy        high whenever the sequencer is not idle
//   err         one-cycle pulse on an unmapped access or an RD/WR collision
module bus_strobe_ctrl #(
  parameter int unsigned NSLV = 4,
  parameter int unsigned DW   = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [11:0]        ADDR,
  input  logic               RD,
  input  logic               WR,
  input  logic [DW-1:0]      din,
  input  logic [NSLV*DW-1:0] rddat,
  output logic [DW-1:0]      dout,
  output logic               dout_oe,
  output logic [NSLV-1:0]    wr_stb,
  output logic [NSLV-1:0]    rd_stb,
  output logic [7:0]         addr,
  output logic [DW-1:0]      wrdat,
  output logic               busy,
  output logic               err
);

  typedef enum logic [2:0] {
    IDLE,
    WR_ISSUE,
    RD_ISSUE,
    RD_LATCH,
    RD_HOLD,
    WAIT_LOW
  } state_e;

  // Strobe synchronisers (s1, s2) and edge-detect stage (s3).
  logic rd_s1_q, rd_s2_q, rd_s3_q;
  logic wr_s1_q, wr_s2_q, wr_s3_q;

  state_e              state_q, state_d;
  logic                init_q;
  logic                armed_q, armed_d;
  logic [3:0]          page_q, page_d;
  logic                coll_q, coll_d;
  logic [7:0]          addr_q, addr_d;
  logic [DW-1:0]       wrdat_q, wrdat_d;
  logic [DW-1:0]       dout_q, dout_d;
  logic                dout_oe_q, dout_oe_d;
  logic [NSLV-1:0]     wr_stb_q, wr_stb_d;
  logic [NSLV-1:0]     rd_stb_q, rd_stb_d;
  logic                err_q, err_d;
  logic                busy_q, busy_d;

  logic                rd_rise, wr_rise;
  logic                mapped;
  logic [NSLV-1:0]     page_onehot;
  logic [DW-1:0]       page_data;

  assign rd_rise = rd_s2_q & ~rd_s3_q;
  assign wr_rise = wr_s2_q & ~wr_s3_q;

  // Page decode. An unmapped page leaves the one-hot and the read data at zero.
  always_comb begin
    mapped      = 32'(page_q) < NSLV;
    page_onehot = '0;
    page_data   = '0;
    for (int unsigned k = 0; k < NSLV; k++) begin
      if (32'(page_q) == k) begin
        page_onehot[k] = 1'b1;
        page_data      = rddat[k*DW +: DW];
      end
    end
  end

  always_comb begin
    state_d   = state_q;
    page_d    = page_q;
    coll_d    = coll_q;
    addr_d    = addr_q;
    wrdat_d   = wrdat_q;
    dout_d    = dout_q;
    dout_oe_d = dout_oe_q;
    wr_stb_d  = '0;
    rd_stb_d  = '0;
    err_d     = 1'b0;

    // Arming is gated by init_q. The synchroniser reset values are not real samples,
    // so both strobes must actually be seen low on the pins. A strobe held high through
    // reset release therefore never looks like a fresh rise.
    armed_d = armed_q | (init_q & ~rd_s1_q & ~rd_s2_q & ~wr_s1_q & ~wr_s2_q);

    unique case (state_q)
      IDLE: begin
        if (armed_q && wr_rise) begin
          addr_d  = ADDR[7:0];
          wrdat_d = din;
          page_d  = ADDR[11:8];
          coll_d  = rd_rise;
          state_d = WR_ISSUE;
        end else if (armed_q && rd_rise) begin
          addr_d  = ADDR[7:0];
          page_d  = ADDR[11:8];
          coll_d  = 1'b0;
          state_d = RD_ISSUE;
        end
      end
      WR_ISSUE: begin
        wr_stb_d = page_onehot;
        err_d    = ~mapped | coll_q;
        state_d  = WAIT_LOW;
      end
      RD_ISSUE: begin
        rd_stb_d = page_onehot;
        err_d    = ~mapped;
        state_d  = RD_LATCH;
      end
      RD_LATCH: begin
        dout_d    = page_data;
        dout_oe_d = 1'b1;
        state_d   = RD_HOLD;
      end
      RD_HOLD: begin
        // A low synchronised level also covers a fall that has already been seen.
        if (!rd_s2_q) begin
          dout_oe_d = 1'b0;
          state_d   = IDLE;
        end
      end
      WAIT_LOW: begin
        if (!wr_s2_q && !rd_s2_q) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_s1_q   <= 1'b0;
      rd_s2_q   <= 1'b0;
      rd_s3_q   <= 1'b0;
      wr_s1_q   <= 1'b0;
      wr_s2_q   <= 1'b0;
      wr_s3_q   <= 1'b0;
      init_q    <= 1'b0;
      armed_q   <= 1'b0;
      state_q   <= IDLE;
      page_q    <= '0;
      coll_q    <= 1'b0;
      addr_q    <= '0;
      wrdat_q   <= '0;
      dout_q    <= '0;
      dout_oe_q <= 1'b0;
      wr_stb_q  <= '0;
      rd_stb_q  <= '0;
      err_q     <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      rd_s1_q   <= RD;
      rd_s2_q   <= rd_s1_q;
      rd_s3_q   <= rd_s2_q;
      wr_s1_q   <= WR;
      wr_s2_q   <= wr_s1_q;
      wr_s3_q   <= wr_s2_q;
      init_q    <= 1'b1;
      armed_q   <= armed_d;
      state_q   <= state_d;
      page_q    <= page_d;
      coll_q    <= coll_d;
      addr_q    <= addr_d;
      wrdat_q   <= wrdat_d;
      dout_q    <= dout_d;
      dout_oe_q <= dout_oe_d;
      wr_stb_q  <= wr_stb_d;
      rd_stb_q  <= rd_stb_d;
      err_q     <= err_d;
      busy_q    <= busy_d;
    end
  end

  assign dout    = dout_q;
  assign dout_oe = dout_oe_q;
  assign wr_stb  = wr_stb_q;
  assign rd_stb  = rd_stb_q;
  assign addr    = addr_q;
  assign wrdat   = wrdat_q;
  assign busy    = busy_q;
  assign err     = err_q;

endmodule
